// File: rtl/fir_stream_dpath.sv
// fir_stream_dpath: UNR-lane streaming FIR with start/drain run control and optional decimate-by-UNR output.
module fir_stream_dpath #(
  parameter int DWIDTH = 14,
  parameter int CWIDTH = 11,
  parameter int UNR = 4,
  parameter int NTAP = 37,
  localparam int OWIDTH = DWIDTH + CWIDTH + 1 + $clog2(NTAP)
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           ASYNC_START,
  input  logic                           DECIM,
  input  logic [31:0]                    DLEN,
  input  logic [NTAP-1:0][CWIDTH-1:0]    coeff,
  input  logic [UNR-1:0][DWIDTH-1:0]     din,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  output logic [UNR-1:0][OWIDTH-1:0]     firsum,
  output logic                           OUT_VALID,
  output logic                           BUSY,
  output logic                           DONE
);
  localparam int PWIDTH = DWIDTH + CWIDTH + 1;
  localparam int WLEN = NTAP - 1 + UNR;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_t;
  state_t state, state_nxt;
  logic [2:0] sync;
  logic [31:0] dlen_r, cnt;
  logic decim_r;
  logic [NTAP-1:0][CWIDTH-1:0] coef_r;
  // win[0] is the newest sample; the first NTAP-1 entries double as the history carried to the next beat
  logic [WLEN-1:0][DWIDTH-1:0] win, win_nxt;
  logic signed [PWIDTH-1:0] prod [UNR][NTAP];
  logic signed [OWIDTH-1:0] sum_c [UNR];
  logic signed [OWIDTH-1:0] sum_r [UNR];
  logic [1:0] dcnt;
  logic v0, v1, v2, start, accept;

  assign start = sync[1] & ~sync[2];
  assign IN_READY = state == RUN;
  assign accept = IN_READY & IN_VALID;
  assign BUSY = state != IDLE;
  assign DONE = state == FIN;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = DLEN == 32'd0 ? FIN : RUN;
      RUN:     state_nxt = accept && cnt + 32'd1 == dlen_r ? DRAIN : RUN;
      DRAIN:   state_nxt = dcnt == 2'd2 ? FIN : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_nxt = win;
    for (int j = 0; j < UNR; j++) win_nxt[j] = din[UNR-1-j];
    for (int j = UNR; j < WLEN; j++) win_nxt[j] = win[j-UNR];
  end

  always_comb
    for (int i = 0; i < UNR; i++) begin
      sum_c[i] = '0;
      for (int k = 0; k < NTAP; k++) sum_c[i] += OWIDTH'(prod[i][k]);
    end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sync <= '0;
      dlen_r <= '0;
      cnt <= '0;
      decim_r <= 1'b0;
      coef_r <= '0;
      win <= '0;
      dcnt <= '0;
      {v0, v1, v2, OUT_VALID} <= '0;
      firsum <= '0;
      for (int i = 0; i < UNR; i++) begin
        sum_r[i] <= '0;
        for (int k = 0; k < NTAP; k++) prod[i][k] <= '0;
      end
    end else begin
      sync <= {sync[1:0], ASYNC_START};
      dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
      {v0, v1, v2, OUT_VALID} <= {accept, v0, v1, v2};
      if (state == LOAD) begin
        dlen_r <= DLEN;
        decim_r <= DECIM;
        coef_r <= coeff;
        win <= '0;
        cnt <= '0;
      end else if (accept) begin
        win <= win_nxt;
        cnt <= cnt + 32'd1;
      end
      if (v0)
        for (int i = 0; i < UNR; i++)
          for (int k = 0; k < NTAP; k++)
            prod[i][k] <= PWIDTH'($signed(win[UNR-1-i+k])) * PWIDTH'($signed({1'b0, coef_r[k]}));
      if (v1)
        for (int i = 0; i < UNR; i++) sum_r[i] <= sum_c[i];
      if (v2)
        for (int i = 0; i < UNR; i++) firsum[i] <= decim_r ? (i == 0 ? sum_r[UNR-1] : '0) : sum_r[i];
    end
endmodule

// File: tb/tb_fir_stream_dpath.sv
// tb_fir_stream_dpath: directed and randomized runs checked against a sample-level FIR model.
module tb_fir_stream_dpath;
  localparam int DW = 14, CW = 11, U = 4, NT = 37;
  localparam int OW = DW + CW + 1 + $clog2(NT);
  typedef logic [U-1:0][OW-1:0] beat_t;
  logic CLK = 0, RST_N = 0, ASYNC_START = 0, DECIM = 0, IN_VALID = 0;
  logic [31:0] DLEN = 0;
  logic [NT-1:0][CW-1:0] coeff = '0;
  logic [U-1:0][DW-1:0] din = '0;
  logic IN_READY, OUT_VALID, BUSY, DONE;
  beat_t firsum;
  int n_assert = 0, n_fail = 0, n_out = 0;
  int xs[];
  int cm[NT];
  beat_t exp_q[$];
  beat_t last_obs = '0;
  beat_t mon_e;

  fir_stream_dpath #(.DWIDTH(DW), .CWIDTH(CW), .UNR(U), .NTAP(NT)) dut (
    .CLK(CLK), .RST_N(RST_N), .ASYNC_START(ASYNC_START), .DECIM(DECIM), .DLEN(DLEN),
    .coeff(coeff), .din(din), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .firsum(firsum),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic longint y_of(int n);
    longint s = 0;
    for (int k = 0; k < NT; k++) if (n - k >= 0) s += longint'(cm[k]) * xs[n-k];
    return s;
  endfunction

  always @(negedge CLK)
    if (!RST_N) last_obs = '0;
    else if (OUT_VALID) begin
      n_out++;
      if (exp_q.size() == 0) check("extra_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < U; i++) check("lane", firsum[i], mon_e[i]);
      end
      last_obs = firsum;
    end else check("hold", firsum, last_obs);

  // kind: 0 random, 1 impulse at x[14], 2 all-ones step, 3 negative full-scale at x[0]
  task automatic do_run(input int dlen, input bit decim, input int kind, input bit gaps,
                        input bit chg, input bit hold, input int abort_at);
    int b, g, cyc;
    bit acc;
    beat_t e;
    for (int k = 0; k < NT; k++) cm[k] = int'(coeff[k]);
    xs = new[dlen * U];
    foreach (xs[j]) xs[j] = kind == 0 ? int'($urandom_range(16383)) - 8192 : (kind == 2 ? 1 : 0);
    if (kind == 1 && dlen * U > 14) xs[14] = 1;
    if (kind == 3 && dlen > 0) xs[0] = -8192;
    exp_q.delete();
    for (int bb = 0; bb < dlen; bb++) begin
      e = '0;
      for (int i = 0; i < U; i++) if (!decim) e[i] = OW'(y_of(bb * U + i));
      if (decim) e[0] = OW'(y_of(bb * U + U - 1));
      exp_q.push_back(e);
    end
    n_out = 0;
    DLEN = dlen;
    DECIM = decim;
    ASYNC_START = 1;
    g = 0;
    while (!BUSY && g < 10) begin @(posedge CLK); #1; g++; end
    check("run_start", BUSY, 1);
    if (!hold) ASYNC_START = 0;
    @(posedge CLK); #1;
    DLEN = $urandom;
    DECIM = ~decim;
    b = 0;
    g = 0;
    while (b < dlen && b != abort_at && g < 4000) begin
      IN_VALID = !gaps || $urandom_range(1) == 1;
      for (int i = 0; i < U; i++) din[i] = DW'(xs[b * U + i]);
      @(negedge CLK);
      acc = IN_VALID && IN_READY;
      @(posedge CLK); #1;
      if (acc) b++;
      if (chg && b == 2) for (int k = 0; k < NT; k++) coeff[k] = CW'($urandom);
      g++;
    end
    IN_VALID = 0;
    check("beats_fed", b, abort_at > 0 ? abort_at : dlen);
    if (abort_at > 0) begin
      repeat (2) @(posedge CLK);
      #3 RST_N = 0;
      #1;
      check("rst_ready", IN_READY, 0);
      check("rst_valid", OUT_VALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_firsum", firsum, 0);
      exp_q.delete();
      repeat (2) @(posedge CLK);
      #3 RST_N = 1;
      repeat (6) @(posedge CLK);
      #1;
      check("post_rst_idle", BUSY, 0);
    end else begin
      if (dlen > 0) check("drain_ready", IN_READY, 0);
      cyc = 0;
      while (!DONE && cyc < 20) begin @(negedge CLK); cyc++; end
      check("done_time", cyc, dlen > 0 ? 4 : 0);
      @(posedge CLK); #1;
      check("done_pulse", DONE, 0);
      check("idle", BUSY, 0);
      repeat (4) @(posedge CLK);
      #1;
      check("out_count", n_out, dlen);
      check("exp_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    #12;
    check("rst_ready0", IN_READY, 0);
    check("rst_valid0", OUT_VALID, 0);
    check("rst_busy0", BUSY, 0);
    check("rst_done0", DONE, 0);
    check("rst_firsum0", firsum, 0);
    #10 RST_N = 1;
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < NT; k++) coeff[k] = CW'(k + 1);
    do_run(14, 0, 1, 0, 0, 0, -1);
    for (int k = 0; k < NT; k++) coeff[k] = CW'(k + 1);
    do_run(12, 0, 2, 0, 0, 0, -1);
    for (int i = 0; i < U; i++) check("step_last", last_obs[i], 703);
    for (int k = 0; k < NT; k++) coeff[k] = 11'd1023;
    do_run(10, 0, 3, 0, 0, 0, -1);
    for (int k = 0; k < NT; k++) coeff[k] = CW'(k + 1);
    do_run(12, 1, 2, 0, 0, 0, -1);
    check("decim_last0", last_obs[0], 703);
    for (int i = 1; i < U; i++) check("decim_zero", last_obs[i], 0);
    for (int k = 0; k < NT; k++) coeff[k] = CW'(k + 1);
    do_run(14, 0, 1, 1, 1, 0, -1);
    repeat (4) begin
      for (int k = 0; k < NT; k++) coeff[k] = CW'($urandom);
      do_run($urandom_range(20, 1), $urandom_range(1) == 1, 0, 1, $urandom_range(1) == 1, 0, -1);
    end
    for (int k = 0; k < NT; k++) coeff[k] = CW'($urandom);
    do_run(20, 0, 0, 0, 0, 0, 6);
    do_run(0, 0, 0, 0, 0, 1, -1);
    repeat (8) begin
      @(posedge CLK); #1;
      check("no_retrigger", BUSY, 0);
    end
    ASYNC_START = 0;
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < NT; k++) coeff[k] = CW'($urandom);
    do_run(9, 0, 0, 1, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
